melody_sequencer: RTL and testbench

MELODY_SEQUENCER -- requirements
Module: melody_sequencer

---
 rtl/melody_pkg.sv | 18 +
 rtl/melody_rom.sv | 46 ++++
 rtl/melody_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_melody_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/melody_pkg.sv
// Shared types and constants for the melody sequencer.
// Song entries are {voice[3:0], dur[3:0]}; a zero duration ends the song.
package melody_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_GAP,
    ST_PAUSED
  } state_e;

  localparam int VOICE_W = 4;
  localparam int DUR_W   = 4;

  localparam logic [VOICE_W-1:0] REST    = '0;
  localparam logic [DUR_W-1:0]   END_DUR = '0;

endpackage

// File: rtl/melody_rom.sv
// Constant song table: 4 songs x SONG_LEN entries, combinational lookup.
// Song 0: two notes, song 1: empty, song 2: full length, song 3: short tune.
module melody_rom
  import melody_pkg::*;
#(
  parameter int SONG_LEN = 32,
  parameter int IDX_W    = $clog2(SONG_LEN)
) (
  input  logic [1:0]         song_sel,
  input  logic [IDX_W-1:0]   note_idx,
  output logic [VOICE_W-1:0] voice,
  output logic [DUR_W-1:0]   dur
);

  always_comb begin
    voice = REST;
    dur   = END_DUR;
    unique case (song_sel)
      2'd0: begin
        if (note_idx == IDX_W'(0)) begin
          voice = 4'd5;
          dur   = 4'd2;
        end else if (note_idx == IDX_W'(1)) begin
          voice = 4'd3;
          dur   = 4'd1;
        end
      end
      2'd1: begin
      end
      2'd2: begin
        voice = VOICE_W'(int'(note_idx) % 15 + 1);
        dur   = 4'd1;
      end
      2'd3: begin
        if (note_idx == IDX_W'(0)) begin
          voice = 4'd9;
          dur   = 4'd1;
        end else if (note_idx == IDX_W'(1)) begin
          voice = 4'd2;
          dur   = 4'd1;
        end
      end
    endcase
  end

endmodule

// File: rtl/melody_sequencer.sv
// Plays a ROM song as timed notes separated by silent gaps.
// Define SONG_LOOP_EN to repeat the song until stop instead of ending.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int BEAT_CYC = 10_000_000,
  parameter int GAP_CYC  = 400_000,
  parameter int SONG_LEN = 32,
  localparam int IDX_W   = $clog2(SONG_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic [1:0]         song_sel,
  output logic [VOICE_W-1:0] voice,
  output logic               busy,
  output logic               done,
  output logic [IDX_W-1:0]   note_idx
);

  localparam int MAX_CYC = (BEAT_CYC > GAP_CYC) ? BEAT_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BEAT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(SONG_LEN - 1);

  state_e             state_q, state_d;
  state_e             ret_q, ret_d;
  logic [1:0]         sel_q, sel_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [DUR_W-1:0]   beat_q, beat_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [VOICE_W-1:0] voice_q, voice_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               gap_end;
  logic [VOICE_W-1:0] nv;
  logic [1:0]         rd_sel;
  logic [IDX_W-1:0]   rd_idx;
  logic [VOICE_W-1:0] rom_voice;
  logic [DUR_W-1:0]   rom_dur;

  // The ROM is addressed with the entry that the next cycle will play.
  always_comb begin
    gap_end = (state_q == ST_GAP) && (cyc_q == GAP_LAST);
    rd_sel  = sel_q;
    rd_idx  = idx_q;
    if (state_q == ST_IDLE) begin
      rd_sel = song_sel;
      rd_idx = '0;
    end else if (gap_end) begin
      rd_idx = idx_q + 1'b1;
    end
  end

  melody_rom #(
    .SONG_LEN(SONG_LEN)
  ) u_rom (
    .song_sel(rd_sel),
    .note_idx(rd_idx),
    .voice   (rom_voice),
    .dur     (rom_dur)
  );

`ifdef SONG_LOOP_EN
  logic [VOICE_W-1:0] head_voice;
  logic [DUR_W-1:0]   head_dur;

  melody_rom #(
    .SONG_LEN(SONG_LEN)
  ) u_head (
    .song_sel(sel_q),
    .note_idx(IDX_W'(0)),
    .voice   (head_voice),
    .dur     (head_dur)
  );
`endif

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    cyc_d   = cyc_q;
    beat_d  = beat_q;
    dur_d   = dur_q;
    done_d  = 1'b0;
    nv      = rom_voice;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sel_d  = song_sel;
          idx_d  = '0;
          cyc_d  = '0;
          beat_d = '0;
          if (rom_dur == END_DUR) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_PLAY;
            dur_d   = rom_dur;
          end
        end
      end
      ST_PLAY: begin
        if (cyc_q == BEAT_LAST) begin
          cyc_d = '0;
          if (beat_q == dur_q - 1'b1) begin
            beat_d  = '0;
            state_d = ST_GAP;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_end) begin
          cyc_d = '0;
          if (idx_q == IDX_LAST || rom_dur == END_DUR) begin
            idx_d = '0;
`ifdef SONG_LOOP_EN
            state_d = ST_PLAY;
            dur_d   = head_dur;
            nv      = head_voice;
`else
            state_d = ST_IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            dur_d   = rom_dur;
            state_d = ST_PLAY;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_PAUSED: begin
        if (!pause) begin
          state_d = ret_q;
        end
      end
    endcase

    // The pausing cycle still counts, so total note time is preserved.
    if (pause && (state_q == ST_PLAY || state_q == ST_GAP)
        && state_d != ST_IDLE) begin
      ret_d   = state_d;
      state_d = ST_PAUSED;
    end

    if (stop) begin
      state_d = ST_IDLE;
      ret_d   = ST_IDLE;
      idx_d   = '0;
      cyc_d   = '0;
      beat_d  = '0;
      done_d  = 1'b0;
    end

    voice_d = (state_d == ST_PLAY) ? nv : REST;
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ret_q   <= ST_IDLE;
      sel_q   <= '0;
      idx_q   <= '0;
      cyc_q   <= '0;
      beat_q  <= '0;
      dur_q   <= '0;
      voice_q <= REST;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      cyc_q   <= cyc_d;
      beat_q  <= beat_d;
      dur_q   <= dur_d;
      voice_q <= voice_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign voice    = voice_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign note_idx = idx_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with BEAT_CYC=4, GAP_CYC=2.
// Song 0 = {5/2, 3/1, END}, 1 = empty, 2 = full length, 3 = {9/1, 2/1, END}.
module tb_melody_sequencer;

  localparam int SONG_LEN = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] song_sel = 2'd0;
  logic [3:0] voice;
  logic       busy;
  logic       done;
  logic [4:0] note_idx;

  int checks = 0;
  int errors = 0;

  melody_sequencer #(
    .BEAT_CYC(4),
    .GAP_CYC (2),
    .SONG_LEN(SONG_LEN)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .pause   (pause),
    .song_sel(song_sel),
    .voice   (voice),
    .busy    (busy),
    .done    (done),
    .note_idx(note_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic [1:0] sel;
    logic [3:0] v;
    logic       b;
    logic       d;
    logic [4:0] idx;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(logic st, logic [1:0] sel, logic [3:0] v,
                              logic b, logic d, logic [4:0] idx);
    vec_t r;
    r.st = st; r.sel = sel; r.v = v; r.b = b; r.d = d; r.idx = idx;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input int v, input int b,
                         input int d, input int idx);
    chk({nm, ".voice"}, int'(voice), v);
    chk({nm, ".busy"}, int'(busy), b);
    chk({nm, ".done"}, int'(done), d);
    chk({nm, ".idx"}, int'(note_idx), idx);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // Nominal song-0 timeline, k = edges since the start edge.
  function automatic int nom_v(int k);
    if (k <= 7) return 5;
    if (k <= 9) return 0;
    if (k <= 13) return 3;
    return 0;
  endfunction

  function automatic int nom_b(int k);
    return (k <= 15) ? 1 : 0;
  endfunction

  initial begin
    int ev, eb, ed, kk, dcnt;

    tbl[0]  = mk(1, 2'd0, 4'd5, 1, 0, 5'd0);
    tbl[1]  = mk(0, 2'd0, 4'd5, 1, 0, 5'd0);
    tbl[2]  = mk(0, 2'd0, 4'd5, 1, 0, 5'd0);
    tbl[3]  = mk(0, 2'd0, 4'd5, 1, 0, 5'd0);
    tbl[4]  = mk(0, 2'd0, 4'd5, 1, 0, 5'd0);
    tbl[5]  = mk(0, 2'd3, 4'd5, 1, 0, 5'd0);
    tbl[6]  = mk(1, 2'd1, 4'd5, 1, 0, 5'd0);
    tbl[7]  = mk(0, 2'd0, 4'd5, 1, 0, 5'd0);
    tbl[8]  = mk(0, 2'd0, 4'd0, 1, 0, 5'd0);
    tbl[9]  = mk(0, 2'd0, 4'd0, 1, 0, 5'd0);
    tbl[10] = mk(0, 2'd0, 4'd3, 1, 0, 5'd1);
    tbl[11] = mk(0, 2'd0, 4'd3, 1, 0, 5'd1);
    tbl[12] = mk(1, 2'd2, 4'd3, 1, 0, 5'd1);
    tbl[13] = mk(0, 2'd0, 4'd3, 1, 0, 5'd1);
    tbl[14] = mk(0, 2'd0, 4'd0, 1, 0, 5'd1);
    tbl[15] = mk(0, 2'd0, 4'd0, 1, 0, 5'd1);
    tbl[16] = mk(0, 2'd0, 4'd0, 0, 1, 5'd0);
    tbl[17] = mk(0, 2'd0, 4'd0, 0, 0, 5'd0);

    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Song 0 basic playback, with song_sel noise and start while busy.
    for (int i = 0; i < 18; i++) begin
      start    = tbl[i].st;
      song_sel = tbl[i].sel;
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].b, tbl[i].d,
              tbl[i].idx);
    end

    // Pause for 10 cycles starting at cycle 3 of the first note.
    song_sel = 2'd0;
    start    = 1'b1;
    for (int k = 0; k <= 27; k++) begin
      pause = (k >= 3 && k <= 12);
      tick();
      if (k >= 3 && k <= 12) begin
        ev = 0; eb = 1; ed = 0;
      end else begin
        kk = (k < 3) ? k : k - 10;
        ev = nom_v(kk); eb = nom_b(kk); ed = (kk == 16) ? 1 : 0;
      end
      chk($sformatf("pause%0d.voice", k), int'(voice), ev);
      chk($sformatf("pause%0d.busy", k), int'(busy), eb);
      chk($sformatf("pause%0d.done", k), int'(done), ed);
    end
    pause = 1'b0;

    // Stop during the second note, then replay from entry 0.
    start = 1'b1;
    repeat (12) tick();
    chk("stop.pre.voice", int'(voice), 3);
    stop = 1'b1;
    tick();
    chk_out("stop", 0, 0, 0, 0);
    dcnt = 0;
    repeat (10) begin
      tick();
      dcnt += int'(done);
    end
    chk("stop.nodone", dcnt, 0);
    start = 1'b1;
    tick();
    chk_out("restart", 5, 1, 0, 0);
    stop = 1'b1;
    tick();

    // Start and stop together from IDLE.
    start = 1'b1;
    stop  = 1'b1;
    tick();
    chk_out("ststp", 0, 0, 0, 0);
    repeat (3) tick();
    chk_out("ststp.later", 0, 0, 0, 0);

    // Empty song.
    song_sel = 2'd1;
    start    = 1'b1;
    tick();
    chk_out("empty", 0, 0, 1, 0);
    tick();
    chk_out("empty.after", 0, 0, 0, 0);

    // Async reset in the gap after the second note.
    song_sel = 2'd0;
    start    = 1'b1;
    repeat (15) tick();
    chk_out("gap.pre", 0, 1, 0, 1);
    rst = 1'b1;
    #1;
    chk_out("rst.async", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_out("rst.after", 0, 0, 0, 0);

    // Full-length song with no END wraps to done after the last entry.
    song_sel = 2'd2;
    start    = 1'b1;
    dcnt     = 0;
    for (int k = 0; k <= 193; k++) begin
      tick();
      dcnt += int'(done);
      if (k < 32 * 6) begin
        ev = ((k % 6) < 4) ? ((k / 6) % 15) + 1 : 0;
        chk($sformatf("full%0d.voice", k), int'(voice), ev);
        chk($sformatf("full%0d.idx", k), int'(note_idx), k / 6);
      end else begin
        chk($sformatf("full%0d.busy", k), int'(busy), 0);
      end
    end
    chk("full.done_cnt", dcnt, 1);

    // Two-note song: ends after one pass, or loops when enabled.
    song_sel = 2'd3;
    start    = 1'b1;
    dcnt     = 0;
    for (int k = 0; k < 36; k++) begin
      tick();
      dcnt += int'(done);
`ifdef SONG_LOOP_EN
      ev = ((k % 6) < 4) ? (((k / 6) % 2 == 0) ? 9 : 2) : 0;
      chk($sformatf("loop%0d.voice", k), int'(voice), ev);
`else
      ev = (k < 12 && (k % 6) < 4) ? ((k < 6) ? 9 : 2) : 0;
      chk($sformatf("two%0d.voice", k), int'(voice), ev);
`endif
    end
`ifdef SONG_LOOP_EN
    chk("loop.done_cnt", dcnt, 0);
    stop = 1'b1;
    tick();
    chk_out("loop.stop", 0, 0, 0, 0);
`else
    chk("two.done_cnt", dcnt, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
